ioexp_in_debounce: RTL



---
 rtl/ioexp_in_debounce.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ioexp_in_debounce.sv
// Per-bit debouncer for the IO-expander input word, queuing {index, level} change events in a show-ahead FIFO.
// Optional: define IOEXP_DEB_TIMESTAMP_EN to add a 16-bit tick timestamp (ev_time) to each event.
module ioexp_in_debounce #(
  parameter int               WIDTH        = 16,
  parameter int               TICK_DIV     = 1000,
  parameter int               STABLE_TICKS = 4,
  parameter int               FIFO_DEPTH   = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         raw_in,
  output logic [WIDTH-1:0]         state,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(WIDTH)-1:0] ev_bit,
  output logic                     ev_level,
`ifdef IOEXP_DEB_TIMESTAMP_EN
  output logic [15:0]              ev_time,
`endif
  output logic                     ev_overflow,
  input  logic                     ovf_clear,
  output logic                     irq
);
  localparam int BW = $clog2(WIDTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef IOEXP_DEB_TIMESTAMP_EN
  localparam int EW = 16 + BW + 1;
`else
  localparam int EW = BW + 1;
`endif

  logic [TW-1:0]          r_tick_cnt;
  logic                   w_tick;
  logic [WIDTH-1:0]       r_state;
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0]       w_toggle;
  logic [WIDTH-1:0]       r_pend;
  logic [WIDTH-1:0]       w_pclr;
  logic [BW-1:0]          w_sel;
  logic                   w_any, w_push, w_pop, w_ovf_set;
  logic                   r_ovf;
  logic [EW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wp, r_rp;
  logic                   w_empty, w_full;
  logic [EW-1:0]          w_entry, w_head;

  // Sample tick
  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // A bit flips once it has differed from the debounced level for STABLE_TICKS samples in a row
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < WIDTH; i++)
      w_toggle[i] = w_tick && (raw_in[i] != r_state[i]) && (r_cnt[i] == CW'(STABLE_TICKS - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_state <= INIT_VALUE;
    end else begin
      r_state <= r_state ^ w_toggle;
      if (w_tick)
        for (int i = 0; i < WIDTH; i++)
          r_cnt[i] <= ((raw_in[i] == r_state[i]) || w_toggle[i]) ? '0 : r_cnt[i] + 1'b1;
    end
  end

  // Lowest pending index wins the single push slot
  always_comb begin
    w_sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (r_pend[i]) w_sel = BW'(i);
  end

  assign w_any     = |r_pend;
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop     = ev_valid && ev_ready;
  assign w_push    = w_any && (!w_full || w_pop);
  assign w_pclr    = w_push ? (WIDTH'(1) << w_sel) : '0;
  assign w_ovf_set = |(w_toggle & r_pend);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_pclr) | w_toggle;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (ovf_clear) r_ovf <= 1'b0;
    end
  end

`ifdef IOEXP_DEB_TIMESTAMP_EN
  logic [15:0] r_ts;
  always_ff @(posedge clk) begin
    if (!reset)      r_ts <= '0;
    else if (w_tick) r_ts <= r_ts + 16'd1;
  end
  assign w_entry = {r_ts, w_sel, r_state[w_sel]};
  assign ev_time = ev_valid ? w_head[EW-1 -: 16] : '0;
`else
  assign w_entry = {w_sel, r_state[w_sel]};
`endif

  // Storage is left unreset; the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  assign w_head      = r_mem[r_rp[AW-1:0]];
  assign ev_valid    = !w_empty;
  assign ev_bit      = ev_valid ? w_head[BW:1] : '0;
  assign ev_level    = ev_valid && w_head[0];
  assign state       = r_state;
  assign ev_overflow = r_ovf;
  assign irq         = ev_valid || r_ovf;
endmodule
